// File: rtl/baser_pkg.sv
// Shared definitions for the BASE-R 66b lane scheduler: block geometry,
// lane count and the scheduler state encoding.
package baser_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int HDR_WIDTH      = 2;
    localparam int FRAME_WIDTH    = DATA_WIDTH + HDR_WIDTH;
    localparam int NUM_LANES      = 4;
    localparam int LANE_IDX_WIDTH = 2;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_EMIT  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/baser_group_fifo.sv
// Group FIFO for the lane scheduler: each entry holds all four 66b blocks of
// one 257b group. Pointers wrap modulo FIFO_DEPTH (2 or 4); occupancy is kept
// in its own counter so full/empty never depend on pointer comparison.
module baser_group_fifo #(
    parameter int FRAME_WIDTH = baser_pkg::FRAME_WIDTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                push,
    input  logic [baser_pkg::NUM_LANES-1:0][FRAME_WIDTH-1:0]    wr_group,
    input  logic                                                pop,
    output logic [baser_pkg::NUM_LANES-1:0][FRAME_WIDTH-1:0]    rd_group,
    output logic [$clog2(FIFO_DEPTH):0]                         count,
    output logic                                                full
);
    import baser_pkg::*;

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int OCC_WIDTH = PTR_WIDTH + 1;

    logic [NUM_LANES-1:0][FRAME_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]                  wr_ptr;
    logic [PTR_WIDTH-1:0]                  rd_ptr;
    logic [OCC_WIDTH-1:0]                  occupancy;

    // Storage needs no reset: contents are only visible while occupancy > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_group;
        end
    end

    // Pointers advance on push/pop and wrap at the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy tracks push minus pop; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign rd_group = mem[rd_ptr];
    assign count    = occupancy;
    assign full     = (occupancy == OCC_WIDTH'(FIFO_DEPTH));

endmodule

// File: rtl/baser_66b_lane_scheduler.sv
// BASE-R 66b lane scheduler: accepts four-block groups from a 257b decoder,
// buffers them in a small group FIFO and serialises them one 66b block per
// transfer, lane 0 first. Statistics counters are built only when the macro
// BASER_SCHED_STATS_EN is defined; otherwise the counter outputs read 0.
module baser_66b_lane_scheduler #(
    parameter int DATA_WIDTH  = baser_pkg::DATA_WIDTH,
    parameter int HDR_WIDTH   = baser_pkg::HDR_WIDTH,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [FRAME_WIDTH-1:0] i_rx_coded_0,
    input  logic [FRAME_WIDTH-1:0] i_rx_coded_1,
    input  logic [FRAME_WIDTH-1:0] i_rx_coded_2,
    input  logic [FRAME_WIDTH-1:0] i_rx_coded_3,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [FRAME_WIDTH-1:0] o_rx_coded,
    output logic [1:0]             o_lane_idx,
    output logic [31:0]            o_group_count,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_stall_count
);
    import baser_pkg::*;

    localparam int OCC_WIDTH = $clog2(FIFO_DEPTH) + 1;

    sched_state_t                          state;
    sched_state_t                          next_state;
    logic [LANE_IDX_WIDTH-1:0]             lane_cnt;
    logic [LANE_IDX_WIDTH-1:0]             lane_cnt_next;
    logic [NUM_LANES-1:0][FRAME_WIDTH-1:0] wr_group;
    logic [NUM_LANES-1:0][FRAME_WIDTH-1:0] head_group;
    logic [OCC_WIDTH-1:0]                  fifo_count;
    logic                                  fifo_full;
    logic                                  emit;
    logic                                  push;
    logic                                  xfer;
    logic                                  last_lane;
    logic                                  pop;

    assign wr_group  = {i_rx_coded_3, i_rx_coded_2, i_rx_coded_1, i_rx_coded_0};
    assign emit      = (state == S_EMIT);
    assign o_ready   = !i_rst && !fifo_full;
    assign push      = i_valid && o_ready;
    assign xfer      = emit && i_ready;
    assign last_lane = (lane_cnt == LANE_IDX_WIDTH'(NUM_LANES - 1));
    assign pop       = xfer && last_lane;

    baser_group_fifo #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_group_fifo (
        .clk      (clk),
        .rst      (i_rst),
        .push     (push),
        .wr_group (wr_group),
        .pop      (pop),
        .rd_group (head_group),
        .count    (fifo_count),
        .full     (fifo_full)
    );

    // State and lane counter registers; reset aborts any partially sent group.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_EMPTY;
            lane_cnt <= '0;
        end else begin
            state    <= next_state;
            lane_cnt <= lane_cnt_next;
        end
    end

    // Next-state, lane advance and output decode; outputs are zero while idle.
    always_comb begin
        next_state    = state;
        lane_cnt_next = lane_cnt;
        o_valid       = 1'b0;
        o_rx_coded    = '0;
        o_lane_idx    = '0;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    next_state = S_EMIT;
                end
            end
            S_EMIT: begin
                o_valid    = 1'b1;
                o_rx_coded = head_group[lane_cnt];
                o_lane_idx = lane_cnt;
                if (xfer) begin
                    lane_cnt_next = last_lane ? '0 : lane_cnt + 1'b1;
                end
                if (pop && (fifo_count == OCC_WIDTH'(1)) && !push) begin
                    next_state = S_EMPTY;
                end
            end
            default: begin
                next_state    = S_EMPTY;
                lane_cnt_next = '0;
            end
        endcase
    end

`ifdef BASER_SCHED_STATS_EN
    logic [31:0] group_cnt;
    logic [31:0] block_cnt;
    logic [31:0] stall_cnt;

    // Free-running statistics: accepted groups, transferred blocks, stalled cycles.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            group_cnt <= '0;
            block_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) begin
                group_cnt <= group_cnt + 32'd1;
            end
            if (xfer) begin
                block_cnt <= block_cnt + 32'd1;
            end
            if (emit && !i_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign o_group_count = group_cnt;
    assign o_block_count = block_cnt;
    assign o_stall_count = stall_cnt;
`else
    assign o_group_count = '0;
    assign o_block_count = '0;
    assign o_stall_count = '0;
`endif

endmodule
